// File: rtl/tmr_reg_scrubber_pkg.sv
// Shared types and constants for the triplicated register scrubber.
package tmr_reg_scrubber_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        CORRECT = 2'd2
    } scrub_state_e;

    localparam int NumCopies = 3;

    // Injection target code meaning "no copy".
    localparam logic [1:0] InjectIgnore = 2'd3;

endpackage

// File: rtl/tmr_reg_scrubber_voter.sv
// Single-bit 2-of-3 majority voter; VoterType selects the gate structure,
// all variants compute the same majority function.
module TMR_voter #(
    parameter int unsigned VoterType = 2
) (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic y_o
);

    if (VoterType == 0) begin : g_classical
        assign y_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    end else if (VoterType == 1) begin : g_kp
        logic diff_ab;
        assign diff_ab = a_i ^ b_i;
        assign y_o     = diff_ab ? c_i : a_i;
    end else begin : g_bn
        logic diff_ab;
        assign diff_ab = a_i ^ b_i;
        assign y_o     = diff_ab ? c_i : b_i;
    end

endmodule

// File: rtl/tmr_reg_scrubber.sv
// Triplicated register with a combinational voted read port and a periodic
// scrub controller that rewrites divergent copies with the voted value.
module tmr_reg_scrubber
    import tmr_reg_scrubber_pkg::*;
#(
    parameter int unsigned          DataWidth     = 32,
    parameter logic [DataWidth-1:0] ResetValue    = '0,
    parameter int                   ScrubInterval = 1024,
    parameter int unsigned          CntWidth      = 8,
    parameter int unsigned          VoterType     = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    input  logic [DataWidth-1:0] wr_data_i,
    output logic [DataWidth-1:0] rd_data_o,
    input  logic                 scrub_en_i,
    input  logic                 scrub_now_i,
    input  logic                 inject_valid_i,
    input  logic [1:0]           inject_copy_i,
    input  logic [DataWidth-1:0] inject_mask_i,
    output logic                 fault_o,
    output logic [2:0]           fault_copy_o,
    output logic [CntWidth-1:0]  err_cnt_o,
    input  logic                 err_cnt_clr_i,
    output logic                 busy_o
);

`ifndef TARGET_SYNTHESIS
    if (ScrubInterval < 1) begin : g_bad_interval
        $fatal(1, "tmr_reg_scrubber: ScrubInterval must be >= 1");
    end
`endif

    localparam int TimerWidth = (ScrubInterval > 1) ? $clog2(ScrubInterval) : 1;
    localparam logic [TimerWidth-1:0] TimerReload = TimerWidth'(ScrubInterval - 1);
    localparam logic [CntWidth-1:0]   CntMax      = '1;

    scrub_state_e state_q, state_d;
    logic [TimerWidth-1:0] timer_q, timer_d;
    logic [DataWidth-1:0]  copy_q [NumCopies];
    logic [DataWidth-1:0]  copy_d [NumCopies];
    logic [DataWidth-1:0]  voted;
    logic [DataWidth-1:0]  vote_q, vote_d;
    logic [NumCopies-1:0]  mismatch;
    logic [NumCopies-1:0]  cmp_q, cmp_d;
    logic [NumCopies-1:0]  fault_copy_q, fault_copy_d;
    logic                  fault_q, fault_d;
    logic [CntWidth-1:0]   err_cnt_q, err_cnt_d;
    logic                  wr_accept;
    logic                  inject_hit;
    logic                  scrub_trigger;

    genvar gi;
    for (gi = 0; gi < DataWidth; gi++) begin : g_vote
        TMR_voter #(
            .VoterType(VoterType)
        ) u_voter (
            .a_i(copy_q[0][gi]),
            .b_i(copy_q[1][gi]),
            .c_i(copy_q[2][gi]),
            .y_o(voted[gi])
        );
    end

    for (gi = 0; gi < NumCopies; gi++) begin : g_cmp
        assign mismatch[gi] = (copy_q[gi] != voted);
    end

    assign rd_data_o     = voted;
    assign wr_accept     = wr_valid_i & wr_ready_o;
    assign scrub_trigger = (scrub_en_i && (timer_q == '0)) || scrub_now_i;
    // Writes and corrections both overwrite every copy, so an injection would be lost anyway.
    assign inject_hit    = inject_valid_i && (inject_copy_i != InjectIgnore)
                           && !wr_accept && (state_q != CORRECT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            IDLE: begin
                if (wr_accept) begin
                    timer_d = timer_q;
                end else if (scrub_trigger) begin
                    state_d = CHECK;
                end else if (scrub_en_i && (timer_q != '0)) begin
                    timer_d = timer_q - TimerWidth'(1);
                end
            end
            CHECK: begin
                if (wr_accept || (mismatch == '0)) begin
                    state_d = IDLE;
                    timer_d = TimerReload;
                end else begin
                    state_d = CORRECT;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = TimerReload;
            end
        endcase
    end

    always_comb begin
        busy_o     = (state_q != IDLE);
        wr_ready_o = (state_q != CORRECT);
    end

    always_comb begin
        for (int k = 0; k < NumCopies; k++) begin
            copy_d[k] = copy_q[k];
            if (state_q == CORRECT) begin
                copy_d[k] = vote_q;
            end else if (wr_accept) begin
                copy_d[k] = wr_data_i;
            end else if (inject_hit && (inject_copy_i == 2'(k))) begin
                copy_d[k] = copy_q[k] ^ inject_mask_i;
            end
        end
    end

    always_comb begin
        vote_d       = (state_q == CHECK) ? voted : vote_q;
        cmp_d        = (state_q == CHECK) ? mismatch : cmp_q;
        fault_d      = (state_q == CORRECT);
        fault_copy_d = (state_q == CORRECT) ? cmp_q : fault_copy_q;
        err_cnt_d    = err_cnt_q;
        // A clear coinciding with a correction still counts that correction.
        if (err_cnt_clr_i) begin
            err_cnt_d = (state_q == CORRECT) ? CntWidth'(1) : '0;
        end else if ((state_q == CORRECT) && (err_cnt_q != CntMax)) begin
            err_cnt_d = err_cnt_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NumCopies; k++) begin
                copy_q[k] <= ResetValue;
            end
            timer_q      <= TimerReload;
            vote_q       <= ResetValue;
            cmp_q        <= '0;
            fault_q      <= 1'b0;
            fault_copy_q <= '0;
            err_cnt_q    <= '0;
        end else begin
            for (int k = 0; k < NumCopies; k++) begin
                copy_q[k] <= copy_d[k];
            end
            timer_q      <= timer_d;
            vote_q       <= vote_d;
            cmp_q        <= cmp_d;
            fault_q      <= fault_d;
            fault_copy_q <= fault_copy_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign fault_o      = fault_q;
    assign fault_copy_o = fault_copy_q;
    assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_tmr_reg_scrubber.sv
// Self-checking bench for tmr_reg_scrubber: vector table, directed scrub
// sequences and a randomized run against a behavioural model.
module tb_tmr_reg_scrubber;

    localparam int          DW = 32;
    localparam int          SI = 4;
    localparam int          CW = 2;
    localparam logic [31:0] RV = 32'hA5A5_0F0F;

    logic          clk;
    logic          rst_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          scrub_en;
    logic          scrub_now;
    logic          inj_valid;
    logic [1:0]    inj_copy;
    logic [DW-1:0] inj_mask;
    logic          fault;
    logic [2:0]    fault_copy;
    logic [CW-1:0] err_cnt;
    logic          err_clr;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    tmr_reg_scrubber #(
        .DataWidth    (DW),
        .ResetValue   (RV),
        .ScrubInterval(SI),
        .CntWidth     (CW),
        .VoterType    (2)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .wr_valid_i    (wr_valid),
        .wr_ready_o    (wr_ready),
        .wr_data_i     (wr_data),
        .rd_data_o     (rd_data),
        .scrub_en_i    (scrub_en),
        .scrub_now_i   (scrub_now),
        .inject_valid_i(inj_valid),
        .inject_copy_i (inj_copy),
        .inject_mask_i (inj_mask),
        .fault_o       (fault),
        .fault_copy_o  (fault_copy),
        .err_cnt_o     (err_cnt),
        .err_cnt_clr_i (err_clr),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          inj;
        logic [1:0]  copy;
        logic [31:0] val;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[6];

    // Behavioural model state (phase: 0 idle, 1 compare, 2 repair).
    logic [31:0] m_copy[3];
    int          m_phase;
    int          m_timer;
    logic [31:0] m_cap;
    logic [2:0]  m_capmask;
    logic        m_fault;
    logic [2:0]  m_fcopy;
    int          m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wr_valid  = 1'b0;
        wr_data   = '0;
        scrub_now = 1'b0;
        inj_valid = 1'b0;
        inj_copy  = 2'd0;
        inj_mask  = '0;
        err_clr   = 1'b0;
    endtask

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = (int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2;
        end
        return r;
    endfunction

    task automatic do_correction(input logic [1:0] cp, input logic [31:0] mask,
                                 input bit clr_in_correct, input logic [31:0] exp_cnt);
        logic [2:0] exp_fc;
        exp_fc    = 3'b001 << cp;
        inj_valid = 1'b1; inj_copy = cp; inj_mask = mask;
        tick();
        inj_valid = 1'b0;
        scrub_now = 1'b1;
        tick();
        scrub_now = 1'b0;
        tick();
        err_clr = clr_in_correct;
        tick();
        err_clr = 1'b0;
        $display("correction copy=%0d mask=%h clr=%0d -> fault=%0b cnt=%0d", cp, mask,
                 clr_in_correct, fault, err_cnt);
        check("corr_fault", fault, 1);
        check("corr_fault_copy", fault_copy, exp_fc);
        check("corr_cnt", err_cnt, exp_cnt);
    endtask

    task automatic model_step();
        logic [31:0] v;
        logic [31:0] n_copy[3];
        bit          wacc;
        v    = maj(m_copy[0], m_copy[1], m_copy[2]);
        wacc = wr_valid && (m_phase != 2);
        for (int k = 0; k < 3; k++) begin
            n_copy[k] = m_copy[k];
            if (m_phase == 2) n_copy[k] = m_cap;
            else if (wacc) n_copy[k] = wr_data;
            else if (inj_valid && inj_copy == 2'(k)) n_copy[k] = m_copy[k] ^ inj_mask;
        end
        if (err_clr) m_cnt = (m_phase == 2) ? 1 : 0;
        else if (m_phase == 2 && m_cnt < (1 << CW) - 1) m_cnt++;
        if (m_phase == 2) m_fcopy = m_capmask;
        m_fault = (m_phase == 2);
        case (m_phase)
            0: begin
                if (wacc) begin
                end else if ((scrub_en && m_timer == 0) || scrub_now) m_phase = 1;
                else if (scrub_en && m_timer > 0) m_timer--;
            end
            1: begin
                m_cap = v;
                for (int k = 0; k < 3; k++) m_capmask[k] = (m_copy[k] != v);
                if (wacc || m_capmask == 3'b000) begin
                    m_phase = 0;
                    m_timer = SI - 1;
                end else m_phase = 2;
            end
            default: begin
                m_phase = 0;
                m_timer = SI - 1;
            end
        endcase
        for (int k = 0; k < 3; k++) m_copy[k] = n_copy[k];
    endtask

    initial begin
        int cnt_edges;
        clear_inputs();
        scrub_en = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd", rd_data, RV);
        check("rst_busy", busy, 0);
        check("rst_ready", wr_ready, 1);
        check("rst_fault", fault, 0);
        check("rst_fault_copy", fault_copy, 0);
        check("rst_cnt", err_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table: writes and injections, voted read after each.
        vecs[0] = '{0, 2'd0, 32'h0000_FFFF, 32'h0000_FFFF};
        vecs[1] = '{1, 2'd0, 32'h0000_00F0, 32'h0000_FFFF};
        vecs[2] = '{1, 2'd3, 32'hFFFF_FFFF, 32'h0000_FFFF};
        vecs[3] = '{1, 2'd1, 32'h0000_00F0, 32'h0000_FF0F};
        vecs[4] = '{1, 2'd2, 32'h0000_000F, 32'h0000_FF0F};
        vecs[5] = '{0, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (vecs[i].inj) begin
                inj_valid = 1'b1; inj_copy = vecs[i].copy; inj_mask = vecs[i].val;
            end else begin
                wr_valid = 1'b1; wr_data = vecs[i].val;
            end
            tick();
            clear_inputs();
            $display("vec %0d inj=%0b copy=%0d val=%h -> rd=%h", i, vecs[i].inj,
                     vecs[i].copy, vecs[i].val, rd_data);
            check("vec_rd", rd_data, vecs[i].exp_rd);
        end

        // Clean scrub: no fault.
        wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF;
        tick();
        wr_valid = 1'b0;
        check("clean_rd", rd_data, 32'hDEAD_BEEF);
        scrub_now = 1'b1;
        tick();
        scrub_now = 1'b0;
        check("clean_busy", busy, 1);
        tick();
        tick();
        $display("clean scrub -> fault=%0b cnt=%0d", fault, err_cnt);
        check("clean_fault", fault, 0);
        check("clean_cnt", err_cnt, 0);

        // Single-bit upset in copy 1, manual scrub.
        inj_valid = 1'b1; inj_copy = 2'd1; inj_mask = 32'h0000_0001;
        tick();
        inj_valid = 1'b0;
        check("inj_rd", rd_data, 32'hDEAD_BEEF);
        scrub_now = 1'b1;
        tick();
        scrub_now = 1'b0;
        check("t1_busy", busy, 1);
        check("t1_rd", rd_data, 32'hDEAD_BEEF);
        tick();
        check("t2_busy", busy, 1);
        check("t2_ready", wr_ready, 0);
        tick();
        $display("manual scrub -> fault=%0b copy=%b cnt=%0d", fault, fault_copy, err_cnt);
        check("t3_fault", fault, 1);
        check("t3_fault_copy", fault_copy, 3'b010);
        check("t3_cnt", err_cnt, 1);
        check("t3_copy1", dut.copy_q[1], 32'hDEAD_BEEF);
        check("t3_busy", busy, 0);
        tick();
        check("t4_fault_pulse", fault, 0);
        check("t4_fault_copy_held", fault_copy, 3'b010);

        // Automatic interval scrub.
        scrub_en = 1'b1;
        inj_valid = 1'b1; inj_copy = 2'd2; inj_mask = 32'hFF00_0000;
        tick();
        inj_valid = 1'b0;
        cnt_edges = 1;
        while (!fault && cnt_edges < 12) begin
            tick();
            cnt_edges++;
        end
        scrub_en = 1'b0;
        $display("auto scrub -> fault after %0d edges copy=%b", cnt_edges, fault_copy);
        check("auto_edges", cnt_edges, 6);
        check("auto_fault_copy", fault_copy, 3'b100);
        check("auto_cnt", err_cnt, 2);
        tick();

        // Write during compare aborts the scrub.
        inj_valid = 1'b1; inj_copy = 2'd0; inj_mask = 32'h0000_00F0;
        tick();
        inj_valid = 1'b0;
        scrub_now = 1'b1;
        tick();
        scrub_now = 1'b0;
        check("abort_busy_check", busy, 1);
        wr_valid = 1'b1; wr_data = 32'h1234_5678;
        tick();
        wr_valid = 1'b0;
        check("abort_idle", busy, 0);
        check("abort_rd", rd_data, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            check("abort_no_fault", fault, 0);
            tick();
        end
        for (int k = 0; k < 3; k++) check("abort_copy", dut.copy_q[k], 32'h1234_5678);
        check("abort_cnt", err_cnt, 2);
        $display("aborted scrub -> cnt=%0d", err_cnt);

        // Saturation and clear.
        do_correction(2'd0, 32'h8000_0000, 0, 3);
        do_correction(2'd1, 32'h0001_0000, 0, 3);
        do_correction(2'd2, 32'h0000_0100, 0, 3);
        do_correction(2'd1, 32'h0F0F_0F0F, 1, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_alone", err_cnt, 0);

        // Reset during repair.
        inj_valid = 1'b1; inj_copy = 2'd1; inj_mask = 32'h0000_0001;
        tick();
        inj_valid = 1'b0;
        scrub_now = 1'b1;
        tick();
        scrub_now = 1'b0;
        tick();
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rd", rd_data, RV);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", wr_ready, 1);
        check("mid_rst_fault", fault, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_fault", fault, 0);
        end
        for (int k = 0; k < 3; k++) check("post_rst_copy", dut.copy_q[k], RV);
        $display("reset during repair -> rd=%h busy=%0b", rd_data, busy);

        // Randomized run against the model, starting from the reset state.
        for (int k = 0; k < 3; k++) m_copy[k] = RV;
        m_phase = 0; m_timer = SI - 1; m_cap = RV; m_capmask = 3'b000;
        m_fault = 1'b0; m_fcopy = 3'b000; m_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            wr_valid  = ($urandom % 8) == 0;
            wr_data   = $urandom;
            scrub_en  = ($urandom % 4) != 0;
            scrub_now = ($urandom % 10) == 0;
            inj_valid = ($urandom % 3) == 0;
            inj_copy  = 2'($urandom % 4);
            inj_mask  = (($urandom % 2) == 0) ? (32'h1 << ($urandom % 32)) : $urandom;
            err_clr   = ($urandom % 40) == 0;
            model_step();
            tick();
            if (wr_valid || inj_valid || fault)
                $display("rand %0d wr=%0b inj=%0b copy=%0d -> rd=%h fault=%0b cnt=%0d",
                         c, wr_valid, inj_valid, inj_copy, rd_data, fault, err_cnt);
            clear_inputs();
            check("rand_rd", rd_data, maj(m_copy[0], m_copy[1], m_copy[2]));
            check("rand_busy", busy, m_phase != 0);
            check("rand_ready", wr_ready, m_phase != 2);
            check("rand_fault", fault, m_fault);
            check("rand_fault_copy", fault_copy, m_fcopy);
            check("rand_cnt", err_cnt, m_cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tmr_reg_scrubber.md
Name: tmr_reg_scrubber

Overview:
- Triplicated state register with a voted read port and a periodic scrub controller that detects and repairs divergent copies.
- Sequences the per-bit majority voters (instantiated DataWidth times): idle/interval timer, compare, write-back correction.
- Provides a fault-injection port for verification.
- Sits beside any long-lived configuration/state register that needs SEU protection, and reports corrections to a fault monitor.

Parameters:
- DataWidth, 32, width of the protected register.
- ResetValue, '0, value loaded into all three copies at reset.
- ScrubInterval, 1024, idle cycles between automatic scrubs. Must be >= 1; 0 triggers $fatal outside TARGET_SYNTHESIS.
- CntWidth, 8, error counter width.
- VoterType, 2, passed unchanged to every voter instance (0 classical, 1 KP, 2 BN).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- wr_valid_i  in  1  write request
- wr_ready_o  out  1  write accepted when valid&ready
- wr_data_i  in  DataWidth  write data
- rd_data_o  out  DataWidth  bitwise-voted value of the three copies
- scrub_en_i  in  1  enables automatic interval scrubbing
- scrub_now_i  in  1  one-shot scrub request, honoured in IDLE only
- inject_valid_i  in  1  fault injection strobe
- inject_copy_i  in  2  target copy 0..2; 3 = ignored
- inject_mask_i  in  DataWidth  bits XORed into the target copy
- fault_o  out  1  one-cycle pulse after a correction
- fault_copy_o  out  3  bit k set if copy k disagreed with the vote; held until the next correction
- err_cnt_o  out  CntWidth  saturating correction count
- err_cnt_clr_i  in  1  synchronous clear of err_cnt_o
- busy_o  out  1  high when the FSM is not in IDLE

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values:
  - copies = ResetValue
  - FSM = IDLE; timer = ScrubInterval-1
  - fault_o = 0, fault_copy_o = 0, err_cnt_o = 0, busy_o = 0, wr_ready_o = 1
  - rd_data_o = ResetValue
- rd_data_o: purely combinational vote of the registered copies. No registered latency.
- wr_ready_o = (state != CORRECT).
- Accepted write: all three copies <= wr_data_i at the clock edge; visible on rd_data_o the next cycle.
- FSM IDLE:
  - Timer decrements only while scrub_en_i=1; it holds otherwise.
  - Go to CHECK when (scrub_en_i && timer==0) || scrub_now_i.
  - An accepted write in the same cycle suppresses the trigger. The timer keeps its value, or holds at 0 so the scrub fires on the next write-free cycle.
- FSM CHECK (1 cycle):
  - Compute mismatch mask m[k] = (copy k != voted value), registered into a compare register.
  - An accepted write in this cycle aborts the scrub: go to IDLE, discard the compare, reload the timer.
  - Else if |m, go to CORRECT; else go to IDLE and reload the timer.
- FSM CORRECT (1 cycle):
  - All copies <= voted value captured in CHECK (registered).
  - Go to IDLE and reload the timer.
  - Next cycle: fault_o=1, fault_copy_o=m, err_cnt_o increments, saturating at 2^CntWidth-1.
- Latency: trigger cycle T, CHECK at T+1, CORRECT at T+2, corrected copies plus fault_o/err_cnt update at T+3.
- Injection: copy[inject_copy_i] ^= inject_mask_i at the edge.
  - Ignored when inject_copy_i==3.
  - Ignored if the same cycle has an accepted write or is a CORRECT cycle (write/correction wins).
- err_cnt_clr_i together with an increment in the same cycle: result is 1. clr alone: 0.
- Reset mid-scrub: everything returns to reset values at once, with no spurious fault_o.
- Simultaneous scrub_now_i while busy: dropped, not queued.

Decomposition:
- Package tmr_reg_scrubber_pkg holds:
  - state enum scrub_state_e {IDLE, CHECK, CORRECT}
  - the copy-index constant NumCopies=3
  - the injection "ignore" code 2'd3
- Sub-module: the existing single-bit TMR_voter, instantiated per bit in a generate loop with VoterType forwarded. No other sub-modules.

Test Plan:
- Reset, then write 0xDEADBEEF -> rd_data_o=0xDEADBEEF next cycle. A scrub with scrub_now_i then produces no fault_o, and err_cnt_o stays 0.
- Inject copy 1, mask 0x00000001, then scrub_now_i at T:
  - rd_data_o stays 0xDEADBEEF throughout.
  - busy_o high T+1..T+2.
  - At T+3: fault_o pulses, fault_copy_o=3'b010, err_cnt_o=1.
  - Copy 1 is restored.
- ScrubInterval=4, scrub_en_i=1, inject copy 2 mask 0xFF000000 -> automatic correction within 4+3 cycles, fault_copy_o=3'b100.
- Write 0x12345678 during CHECK after an injection -> scrub aborts, no fault_o, all copies=0x12345678, err_cnt_o unchanged.
- CntWidth=2: perform 5 corrections -> err_cnt_o saturates at 3. err_cnt_clr_i coincident with a 6th increment -> err_cnt_o=1.
- Assert rst_ni low during CORRECT -> copies=ResetValue, fault_o never pulses, FSM in IDLE, wr_ready_o=1.
